pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter LU_STALL_CYC, default 1, meaning total bubble cycles inserted per load-use hazard (legal 1..7).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of each performance counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 lu_halt  input  1  load-use hazard request from hazard detection (ID depends on load in EX).
REQ-006 br_taken  input  1  EX-stage branch/jump resolved taken; PC redirect this cycle.
REQ-007 halt_req  input  1  pulse: retiring ebreak/ecall; stop fetch.
REQ-008 resume  input  1  pulse: leave HALTED.
REQ-009 cnt_clr  input  1  synchronous clear of both counters.
REQ-010 pc_we  output  1  PC register write enable.
REQ-011 ifid_we  output  1  IF/ID register write enable.
REQ-012 ifid_flush  output  1  IF/ID register load NOP.
REQ-013 idex_flush  output  1  ID/EX register load NOP (bubble).
REQ-014 halted  output  1  core halted.
REQ-015 stall_cnt  output  CNT_W  count of load-use bubble cycles.
REQ-016 flush_cnt  output  CNT_W  count of branch flush events.

Function
REQ-017 SHALL implement FSM states RUN, LU_STALL, HALTED; control outputs are combinational from state and current inputs.
REQ-018 RUN, no events: pc_we=1, ifid_we=1, ifid_flush=0, idex_flush=0.
REQ-019 RUN, lu_halt=1, br_taken=0: pc_we=0, ifid_we=0, idex_flush=1 same cycle (zero added latency); if LU_STALL_CYC>1 next state LU_STALL with remaining counter loaded to LU_STALL_CYC-1, else stay RUN.
REQ-020 LU_STALL: pc_we=0, ifid_we=0, idex_flush=1; remaining counter decrements each cycle; at remaining==1 next state RUN; lu_halt ignored in this state.
REQ-021 br_taken=1 in RUN or LU_STALL: pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1; branch wins over lu_halt; next state RUN, remaining counter cleared.
REQ-022 halt_req=1 in RUN or LU_STALL: next state HALTED; current cycle outputs per REQ-018..021 (retiring instruction completes).
REQ-023 simultaneous halt_req and br_taken: flush outputs this cycle, next state HALTED.
REQ-024 HALTED: pc_we=0, ifid_we=0, ifid_flush=0, idex_flush=1, halted=1; br_taken, lu_halt, halt_req ignored.
REQ-025 HALTED with resume=1: next state RUN; outputs this cycle still per REQ-024; resume outside HALTED ignored.
REQ-026 stall_cnt SHALL increment by 1 on every cycle where idex_flush=1 caused by load-use (REQ-019/020 paths, not overridden by br_taken); saturates at 2^CNT_W-1.
REQ-027 flush_cnt SHALL increment by 1 on every cycle with an accepted br_taken (REQ-021 path, not in HALTED); saturates at 2^CNT_W-1.
REQ-028 cnt_clr SHALL zero both counters next edge, overriding a same-cycle increment; state unaffected.
REQ-029 halted output SHALL equal (state==HALTED), registered, no combinational path from halt_req.

Reset
REQ-030 rst=1 SHALL set state RUN, remaining counter 0, stall_cnt=0, flush_cnt=0, halted=0 at next edge.
REQ-031 during rst=1 outputs SHALL be pc_we=0, ifid_we=0, ifid_flush=1, idex_flush=1.
REQ-032 rst asserted mid LU_STALL or HALTED SHALL abort it; first cycle after rst deassert behaves as RUN.
REQ-033 rst SHALL override resume, halt_req, cnt_clr.

Verification
REQ-034 LU_STALL_CYC=1: lu_halt=1 one cycle -> pc_we=0, ifid_we=0, idex_flush=1 that cycle only; stall_cnt 0->1.
REQ-035 LU_STALL_CYC=3: lu_halt=1 one cycle -> 3 consecutive bubble cycles, then pc_we=1; stall_cnt=3.
REQ-036 lu_halt=1 and br_taken=1 same cycle -> ifid_flush=1, idex_flush=1, pc_we=1; flush_cnt=1, stall_cnt=0, state RUN.
REQ-037 halt_req pulse -> halted=1 next cycle, pc_we=0 held 10 cycles despite br_taken pulses; resume pulse -> pc_we=1 cycle after.
REQ-038 CNT_W=4: 20 load-use events -> stall_cnt=15; cnt_clr -> 0 next cycle.
REQ-039 rst asserted on 2nd cycle of 3-cycle LU_STALL -> after deassert, lu_halt=0 gives pc_we=1 immediately; counters 0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: inserts load-use bubbles, flushes on taken
// branches, parks the core in a halted state, and keeps two saturating
// performance counters (load-use bubble cycles, branch flush events).
//
// Handshake note: there are no valid/ready pairs here. Every input is a level
// sampled on the rising clock edge, and every control output is valid for
// the cycle in which it is presented.
module pipe_stall_ctrl #(
    parameter int LU_STALL_CYC = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lu_halt,
    input  logic             br_taken,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             cnt_clr,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        HALTED   = 2'd2
    } state_t;

    localparam logic [2:0]       REM_INIT = 3'(LU_STALL_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t     state, state_nxt;
    logic [2:0] rem, rem_nxt;
    logic       stall_inc, flush_inc;

    // State and remaining-bubble register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            rem   <= 3'd0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    // Next state, control outputs and counter increment qualifiers.
    always_comb begin
        state_nxt  = state;
        rem_nxt    = rem;
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (rst) begin
            // Hold the front end and flush both stage registers while in reset.
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_nxt  = RUN;
            rem_nxt    = 3'd0;
        end else begin
            case (state)
                RUN, LU_STALL: begin
                    if (br_taken) begin
                        // Redirect wins over any pending load-use bubble.
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_inc  = 1'b1;
                        state_nxt  = RUN;
                        rem_nxt    = 3'd0;
                    end else if (state == LU_STALL) begin
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                        if (rem <= 3'd1) begin
                            state_nxt = RUN;
                            rem_nxt   = 3'd0;
                        end else begin
                            rem_nxt = rem - 3'd1;
                        end
                    end else if (lu_halt) begin
                        // First bubble is inserted in the same cycle.
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                        if (LU_STALL_CYC > 1) begin
                            state_nxt = LU_STALL;
                            rem_nxt   = REM_INIT;
                        end
                    end
                    // The retiring instruction completes; the halt takes effect next cycle.
                    if (halt_req) begin
                        state_nxt = HALTED;
                        rem_nxt   = 3'd0;
                    end
                end
                HALTED: begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                    if (resume) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    rem_nxt   = 3'd0;
                end
            endcase
        end
    end

    // Saturating performance counters; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_inc && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    // Halted is decoded from the state register only, never from halt_req.
    assign halted    = (state == HALTED);
    assign dbg_state = state;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed testbench for pipe_stall_ctrl. Two instances share the stimulus:
// d1 uses a single-cycle load-use bubble and 4-bit counters, d3 uses a
// three-cycle bubble and 16-bit counters.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rst, lu_halt, br_taken, halt_req, resume, cnt_clr;

    logic        d1_pc_we, d1_ifid_we, d1_ifid_flush, d1_idex_flush, d1_halted;
    logic [3:0]  d1_stall_cnt, d1_flush_cnt;
    logic [1:0]  d1_state;
    logic        d3_pc_we, d3_ifid_we, d3_ifid_flush, d3_idex_flush, d3_halted;
    logic [15:0] d3_stall_cnt, d3_flush_cnt;
    logic [1:0]  d3_state;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Clock generation.
    always #5 clk = ~clk;

    pipe_stall_ctrl #(.LU_STALL_CYC(1), .CNT_W(4)) d1 (
        .clk(clk), .rst(rst), .lu_halt(lu_halt), .br_taken(br_taken),
        .halt_req(halt_req), .resume(resume), .cnt_clr(cnt_clr),
        .pc_we(d1_pc_we), .ifid_we(d1_ifid_we), .ifid_flush(d1_ifid_flush),
        .idex_flush(d1_idex_flush), .halted(d1_halted),
        .stall_cnt(d1_stall_cnt), .flush_cnt(d1_flush_cnt), .dbg_state(d1_state)
    );

    pipe_stall_ctrl #(.LU_STALL_CYC(3), .CNT_W(16)) d3 (
        .clk(clk), .rst(rst), .lu_halt(lu_halt), .br_taken(br_taken),
        .halt_req(halt_req), .resume(resume), .cnt_clr(cnt_clr),
        .pc_we(d3_pc_we), .ifid_we(d3_ifid_we), .ifid_flush(d3_ifid_flush),
        .idex_flush(d3_idex_flush), .halted(d3_halted),
        .stall_cnt(d3_stall_cnt), .flush_cnt(d3_flush_cnt), .dbg_state(d3_state)
    );

    // Advance one cycle; inputs change 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample point: the falling edge, mid-cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        lu_halt = 0; br_taken = 0; halt_req = 0; resume = 0; cnt_clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        // Reset must win over halt_req, resume and cnt_clr.
        rst = 1; lu_halt = 0; br_taken = 0; halt_req = 1; resume = 1; cnt_clr = 1;
        sample();
        chk_cnt++;
        if ({d1_pc_we, d1_ifid_we, d1_ifid_flush, d1_idex_flush} !== 4'b0011)
            $display("FAIL reset_outputs: got %b want 0011",
                     {d1_pc_we, d1_ifid_we, d1_ifid_flush, d1_idex_flush});
        else pass_cnt++;
        tick();
        tick();
        idle_inputs();
        rst = 0;
        sample();
        chk_cnt++;
        if ({d3_halted, d3_stall_cnt, d3_flush_cnt} !== 33'd0)
            $display("FAIL reset_state: halted=%b stall=%0d flush=%0d want 0/0/0",
                     d3_halted, d3_stall_cnt, d3_flush_cnt);
        else pass_cnt++;
        chk_cnt++;
        if ({d3_pc_we, d3_ifid_we, d3_ifid_flush, d3_idex_flush} !== 4'b1100)
            $display("FAIL reset_run_outputs: got %b want 1100",
                     {d3_pc_we, d3_ifid_we, d3_ifid_flush, d3_idex_flush});
        else pass_cnt++;
    endtask

    task automatic test_lu_single();
        do_reset();
        lu_halt = 1;
        sample();
        chk_cnt++;
        if ({d1_pc_we, d1_ifid_we, d1_ifid_flush, d1_idex_flush} !== 4'b0001)
            $display("FAIL lu1_bubble: got %b want 0001",
                     {d1_pc_we, d1_ifid_we, d1_ifid_flush, d1_idex_flush});
        else pass_cnt++;
        tick();
        lu_halt = 0;
        sample();
        chk_cnt++;
        if (d1_pc_we !== 1'b1 || d1_idex_flush !== 1'b0 || d1_stall_cnt !== 4'd1)
            $display("FAIL lu1_after: pc_we=%b idex_flush=%b stall=%0d want 1/0/1",
                     d1_pc_we, d1_idex_flush, d1_stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_lu_multi();
        do_reset();
        // lu_halt held across the stall must not extend it.
        lu_halt = 1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk_cnt++;
            if (d3_pc_we !== 1'b0 || d3_ifid_we !== 1'b0 || d3_idex_flush !== 1'b1)
                $display("FAIL lu3_bubble%0d: pc_we=%b ifid_we=%b idex_flush=%b want 0/0/1",
                         i, d3_pc_we, d3_ifid_we, d3_idex_flush);
            else pass_cnt++;
            tick();
            if (i == 2) lu_halt = 0;
        end
        sample();
        chk_cnt++;
        if (d3_pc_we !== 1'b1 || d3_stall_cnt !== 16'd3)
            $display("FAIL lu3_after: pc_we=%b stall=%0d want 1/3", d3_pc_we, d3_stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_branch_wins();
        do_reset();
        lu_halt = 1; br_taken = 1;
        sample();
        chk_cnt++;
        if ({d3_pc_we, d3_ifid_we, d3_ifid_flush, d3_idex_flush} !== 4'b1111)
            $display("FAIL br_over_lu: got %b want 1111",
                     {d3_pc_we, d3_ifid_we, d3_ifid_flush, d3_idex_flush});
        else pass_cnt++;
        tick();
        idle_inputs();
        sample();
        chk_cnt++;
        if (d3_pc_we !== 1'b1 || d3_flush_cnt !== 16'd1 || d3_stall_cnt !== 16'd0)
            $display("FAIL br_over_lu_after: pc_we=%b flush=%0d stall=%0d want 1/1/0",
                     d3_pc_we, d3_flush_cnt, d3_stall_cnt);
        else pass_cnt++;
        // Branch in the second bubble cycle aborts the stall.
        lu_halt = 1;
        tick();
        lu_halt = 0; br_taken = 1;
        sample();
        chk_cnt++;
        if ({d3_pc_we, d3_ifid_flush, d3_idex_flush} !== 3'b111)
            $display("FAIL br_in_stall: got %b want 111",
                     {d3_pc_we, d3_ifid_flush, d3_idex_flush});
        else pass_cnt++;
        tick();
        br_taken = 0;
        sample();
        chk_cnt++;
        if (d3_pc_we !== 1'b1 || d3_stall_cnt !== 16'd1 || d3_flush_cnt !== 16'd2)
            $display("FAIL br_in_stall_after: pc_we=%b stall=%0d flush=%0d want 1/1/2",
                     d3_pc_we, d3_stall_cnt, d3_flush_cnt);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        do_reset();
        halt_req = 1;
        sample();
        chk_cnt++;
        if (d3_pc_we !== 1'b1 || d3_halted !== 1'b0)
            $display("FAIL halt_req_cycle: pc_we=%b halted=%b want 1/0", d3_pc_we, d3_halted);
        else pass_cnt++;
        tick();
        halt_req = 0;
        for (int i = 0; i < 10; i++) begin
            br_taken = i[0];
            lu_halt  = ~i[0];
            sample();
            chk_cnt++;
            if ({d3_halted, d3_pc_we, d3_ifid_we, d3_ifid_flush, d3_idex_flush} !== 5'b10001)
                $display("FAIL halted_hold%0d: got %b want 10001", i,
                         {d3_halted, d3_pc_we, d3_ifid_we, d3_ifid_flush, d3_idex_flush});
            else pass_cnt++;
            tick();
        end
        idle_inputs();
        resume = 1;
        sample();
        chk_cnt++;
        if (d3_pc_we !== 1'b0 || d3_halted !== 1'b1 || d3_flush_cnt !== 16'd0 || d3_stall_cnt !== 16'd0)
            $display("FAIL resume_cycle: pc_we=%b halted=%b flush=%0d stall=%0d want 0/1/0/0",
                     d3_pc_we, d3_halted, d3_flush_cnt, d3_stall_cnt);
        else pass_cnt++;
        tick();
        sample();
        chk_cnt++;
        if (d3_pc_we !== 1'b1 || d3_halted !== 1'b0)
            $display("FAIL resumed: pc_we=%b halted=%b want 1/0", d3_pc_we, d3_halted);
        else pass_cnt++;
        // resume while running is a no-op; halt together with branch flushes first.
        tick();
        resume = 0; halt_req = 1; br_taken = 1;
        sample();
        chk_cnt++;
        if ({d3_pc_we, d3_ifid_flush, d3_idex_flush, d3_halted} !== 4'b1110)
            $display("FAIL halt_with_br: got %b want 1110",
                     {d3_pc_we, d3_ifid_flush, d3_idex_flush, d3_halted});
        else pass_cnt++;
        tick();
        idle_inputs();
        sample();
        chk_cnt++;
        if (d3_halted !== 1'b1 || d3_flush_cnt !== 16'd1)
            $display("FAIL halt_with_br_after: halted=%b flush=%0d want 1/1", d3_halted, d3_flush_cnt);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        do_reset();
        lu_halt = 1;
        for (int i = 0; i < 20; i++) tick();
        sample();
        chk_cnt++;
        if (d1_stall_cnt !== 4'd15)
            $display("FAIL stall_saturate: got %0d want 15", d1_stall_cnt);
        else pass_cnt++;
        // Clear overrides the increment from the still-active hazard.
        cnt_clr = 1;
        tick();
        cnt_clr = 0; lu_halt = 0;
        sample();
        chk_cnt++;
        if (d1_stall_cnt !== 4'd0 || d1_flush_cnt !== 4'd0)
            $display("FAIL cnt_clr: stall=%0d flush=%0d want 0/0", d1_stall_cnt, d1_flush_cnt);
        else pass_cnt++;
    endtask

    task automatic test_clr_keeps_state();
        do_reset();
        lu_halt = 1;
        tick();
        lu_halt = 0; cnt_clr = 1;
        tick();
        cnt_clr = 0;
        sample();
        chk_cnt++;
        if (d3_pc_we !== 1'b0 || d3_stall_cnt !== 16'd0)
            $display("FAIL clr_in_stall: pc_we=%b stall=%0d want 0/0", d3_pc_we, d3_stall_cnt);
        else pass_cnt++;
        tick();
        sample();
        chk_cnt++;
        if (d3_pc_we !== 1'b1 || d3_stall_cnt !== 16'd1)
            $display("FAIL clr_in_stall_after: pc_we=%b stall=%0d want 1/1", d3_pc_we, d3_stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_rst_abort();
        do_reset();
        lu_halt = 1;
        tick();
        lu_halt = 0; rst = 1;
        sample();
        chk_cnt++;
        if ({d3_pc_we, d3_ifid_we, d3_ifid_flush, d3_idex_flush} !== 4'b0011)
            $display("FAIL rst_mid_stall_outputs: got %b want 0011",
                     {d3_pc_we, d3_ifid_we, d3_ifid_flush, d3_idex_flush});
        else pass_cnt++;
        tick();
        rst = 0;
        sample();
        chk_cnt++;
        if (d3_pc_we !== 1'b1 || d3_stall_cnt !== 16'd0 || d3_flush_cnt !== 16'd0)
            $display("FAIL rst_mid_stall_after: pc_we=%b stall=%0d flush=%0d want 1/0/0",
                     d3_pc_we, d3_stall_cnt, d3_flush_cnt);
        else pass_cnt++;
        halt_req = 1;
        tick();
        halt_req = 0; rst = 1;
        tick();
        rst = 0;
        sample();
        chk_cnt++;
        if (d1_halted !== 1'b0 || d1_pc_we !== 1'b1)
            $display("FAIL rst_mid_halt: halted=%b pc_we=%b want 0/1", d1_halted, d1_pc_we);
        else pass_cnt++;
    endtask

    // Test sequence and final report.
    initial begin
        idle_inputs();
        rst = 1;
        tick();
        test_reset();
        test_lu_single();
        test_lu_multi();
        test_branch_wins();
        test_halt();
        test_saturate();
        test_clr_keeps_state();
        test_rst_abort();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
